// File: rtl/ysyx_22050019_lsu_pkg.sv
// Shared definitions for the LSU-to-AXI bridge.
//   lsu_state_e   : bridge FSM states (also visible on the debug port)
//   lsu_size_e    : access size encoding used on the LSU request port
//   RESP_OKAY     : AXI OKAY response code
//   size_mask()   : byte-enable mask for a size, right-aligned
//   is_misaligned : true when an access would cross the 8-byte beat
package ysyx_22050019_lsu_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_AW   = 3'd3,
    S_W    = 3'd4,
    S_B    = 3'd5,
    S_ERR  = 3'd6
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } lsu_size_e;

  function automatic logic [7:0] size_mask(lsu_size_e sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = 8'h01;
      SZ_H:    m = 8'h03;
      SZ_W:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  // An access fits the beat only if offset + byte count <= 8.
  function automatic logic is_misaligned(logic [2:0] lo, lsu_size_e sz);
    logic [3:0] nbytes;
    nbytes = 4'd1 << sz;
    return ({1'b0, lo} + nbytes) > 4'd8;
  endfunction

endpackage

// File: rtl/ysyx_22050019_lsu_axi_master_if.sv
// Bundles the LSU request/response port and the five AXI channels of the
// bridge. Signal names carry the bridge's point of view (_i = into bridge).
//   master : the bridge side (drives requests' responses and AXI masters)
//   slave  : the environment side (core LSU + AXI SRAM slave)
//
// Handshake rule on every valid/ready pair: a transfer happens on a rising
// clock edge where both are high; the source keeps valid and its payload
// stable until that edge; a ready may be raised without waiting for valid.
interface ysyx_22050019_lsu_axi_master_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64
);
  // LSU side
  logic                      lsu_req_valid_i;
  logic                      lsu_req_ready_o;
  logic                      lsu_req_wen_i;
  logic [AXI_ADDR_WIDTH-1:0] lsu_req_addr_i;
  logic [AXI_DATA_WIDTH-1:0] lsu_req_wdata_i;
  logic [1:0]                lsu_req_size_i;
  logic                      lsu_req_signed_i;
  logic                      lsu_resp_valid_o;
  logic [AXI_DATA_WIDTH-1:0] lsu_resp_rdata_o;
  logic                      lsu_resp_err_o;
  // AXI write address / data / response
  logic                      axi_aw_valid_o;
  logic                      axi_aw_ready_i;
  logic [AXI_ADDR_WIDTH-1:0] axi_aw_addr_o;
  logic                      axi_w_valid_o;
  logic                      axi_w_ready_i;
  logic [AXI_DATA_WIDTH-1:0] axi_w_data_o;
  logic [7:0]                axi_w_strb_o;
  logic                      axi_b_valid_i;
  logic                      axi_b_ready_o;
  logic [1:0]                axi_b_resp_i;
  // AXI read address / data
  logic                      axi_ar_valid_o;
  logic                      axi_ar_ready_i;
  logic [AXI_ADDR_WIDTH-1:0] axi_ar_addr_o;
  logic                      axi_r_valid_i;
  logic                      axi_r_ready_o;
  logic [1:0]                axi_r_resp_i;
  logic [AXI_DATA_WIDTH-1:0] axi_r_data_i;

  modport master (
    input  lsu_req_valid_i, lsu_req_wen_i, lsu_req_addr_i, lsu_req_wdata_i,
           lsu_req_size_i, lsu_req_signed_i,
           axi_aw_ready_i, axi_w_ready_i, axi_b_valid_i, axi_b_resp_i,
           axi_ar_ready_i, axi_r_valid_i, axi_r_resp_i, axi_r_data_i,
    output lsu_req_ready_o, lsu_resp_valid_o, lsu_resp_rdata_o, lsu_resp_err_o,
           axi_aw_valid_o, axi_aw_addr_o, axi_w_valid_o, axi_w_data_o,
           axi_w_strb_o, axi_b_ready_o, axi_ar_valid_o, axi_ar_addr_o,
           axi_r_ready_o
  );

  modport slave (
    output lsu_req_valid_i, lsu_req_wen_i, lsu_req_addr_i, lsu_req_wdata_i,
           lsu_req_size_i, lsu_req_signed_i,
           axi_aw_ready_i, axi_w_ready_i, axi_b_valid_i, axi_b_resp_i,
           axi_ar_ready_i, axi_r_valid_i, axi_r_resp_i, axi_r_data_i,
    input  lsu_req_ready_o, lsu_resp_valid_o, lsu_resp_rdata_o, lsu_resp_err_o,
           axi_aw_valid_o, axi_aw_addr_o, axi_w_valid_o, axi_w_data_o,
           axi_w_strb_o, axi_b_ready_o, axi_ar_valid_o, axi_ar_addr_o,
           axi_r_ready_o
  );
endinterface

// File: rtl/ysyx_22050019_lsu_align.sv
// Byte-lane alignment for the LSU bridge (purely combinational).
//   addr_lo_i  : byte offset within the 8-byte beat
//   size_i     : access size
//   signed_i   : sign-extend loads when 1
//   st_data_i  : right-aligned store data -> st_data_o on its byte lanes
//   st_strb_o  : write strobes for the store
//   ld_raw_i   : raw 64-bit read beat -> ld_data_o extracted and extended
module ysyx_22050019_lsu_align
  import ysyx_22050019_lsu_pkg::*;
(
  input  logic [2:0]  addr_lo_i,
  input  lsu_size_e   size_i,
  input  logic        signed_i,
  input  logic [63:0] st_data_i,
  output logic [63:0] st_data_o,
  output logic [7:0]  st_strb_o,
  input  logic [63:0] ld_raw_i,
  output logic [63:0] ld_data_o
);

  logic [5:0]  bit_off;
  logic [63:0] ld_shifted;

  assign bit_off    = {addr_lo_i, 3'b000};
  assign st_data_o  = st_data_i << bit_off;
  assign st_strb_o  = size_mask(size_i) << addr_lo_i;
  assign ld_shifted = ld_raw_i >> bit_off;

  always_comb begin
    ld_data_o = '0;
    case (size_i)
      SZ_B:    ld_data_o = {{56{signed_i & ld_shifted[7]}},  ld_shifted[7:0]};
      SZ_H:    ld_data_o = {{48{signed_i & ld_shifted[15]}}, ld_shifted[15:0]};
      SZ_W:    ld_data_o = {{32{signed_i & ld_shifted[31]}}, ld_shifted[31:0]};
      default: ld_data_o = ld_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22050019_lsu_axi_master.sv
// LSU-to-AXI bridge: takes one load/store request at a time, runs a single
// AXI read (AR->R) or write (AW->W->B) and returns a one-cycle response.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : LSU request/response port and AXI channels (master view)
//   dbg_state_o  : current FSM state, for observation only
module ysyx_22050019_lsu_axi_master
  import ysyx_22050019_lsu_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  ysyx_22050019_lsu_axi_master_if.master  bus,
  output lsu_state_e                      dbg_state_o
);

  lsu_state_e                state_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  lsu_size_e                 size_q;
  logic                      signed_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [7:0]                strb_q;
  logic                      ar_valid_q;
  logic                      r_ready_q;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      b_ready_q;
  logic                      resp_valid_q;
  logic                      resp_err_q;
  logic [AXI_DATA_WIDTH-1:0] resp_rdata_q;

  // The aligner serves the store path at acceptance (live request fields)
  // and the load path in R (registered fields), so its inputs are muxed.
  logic [2:0]  addr_lo_d;
  lsu_size_e   size_d;
  logic [63:0] st_data;
  logic [7:0]  st_strb;
  logic [63:0] ld_data;
  logic        req_misaligned;

  assign addr_lo_d      = (state_q == S_IDLE) ? bus.lsu_req_addr_i[2:0] : addr_q[2:0];
  assign size_d         = (state_q == S_IDLE) ? lsu_size_e'(bus.lsu_req_size_i) : size_q;
  assign req_misaligned = is_misaligned(bus.lsu_req_addr_i[2:0],
                                        lsu_size_e'(bus.lsu_req_size_i));

  ysyx_22050019_lsu_align u_align (
    .addr_lo_i (addr_lo_d),
    .size_i    (size_d),
    .signed_i  (signed_q),
    .st_data_i (bus.lsu_req_wdata_i),
    .st_data_o (st_data),
    .st_strb_o (st_strb),
    .ld_raw_i  (bus.axi_r_data_i),
    .ld_data_o (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // Response is a single-cycle pulse unless a state below raises it.
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.lsu_req_valid_i) begin
            addr_q   <= bus.lsu_req_addr_i;
            size_q   <= lsu_size_e'(bus.lsu_req_size_i);
            signed_q <= bus.lsu_req_signed_i;
            if (req_misaligned) begin
              // No bus traffic; the error response appears while in ERR.
              state_q      <= S_ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (bus.lsu_req_wen_i) begin
              wdata_q    <= st_data;
              strb_q     <= st_strb;
              aw_valid_q <= 1'b1;
              state_q    <= S_AW;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= S_AR;
            end
          end
        end
        S_AR: begin
          if (bus.axi_ar_ready_i) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= S_R;
          end
        end
        S_R: begin
          if (bus.axi_r_valid_i) begin
            r_ready_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= (bus.axi_r_resp_i != RESP_OKAY);
            resp_rdata_q <= ld_data;
            state_q      <= S_IDLE;
          end
        end
        S_AW: begin
          if (bus.axi_aw_ready_i) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            state_q    <= S_W;
          end
        end
        S_W: begin
          if (bus.axi_w_ready_i) begin
            w_valid_q <= 1'b0;
            b_ready_q <= 1'b1;
            state_q   <= S_B;
          end
        end
        S_B: begin
          if (bus.axi_b_valid_i) begin
            b_ready_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= (bus.axi_b_resp_i != RESP_OKAY);
            resp_rdata_q <= '0;
            state_q      <= S_IDLE;
          end
        end
        S_ERR: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.lsu_req_ready_o  = (state_q == S_IDLE);
  assign bus.lsu_resp_valid_o = resp_valid_q;
  assign bus.lsu_resp_err_o   = resp_err_q;
  assign bus.lsu_resp_rdata_o = resp_rdata_q;

  // Bus addresses are beat-aligned; the low bits only steer byte lanes.
  assign bus.axi_ar_valid_o = ar_valid_q;
  assign bus.axi_ar_addr_o  = {addr_q[AXI_ADDR_WIDTH-1:3], 3'b000};
  assign bus.axi_r_ready_o  = r_ready_q;
  assign bus.axi_aw_valid_o = aw_valid_q;
  assign bus.axi_aw_addr_o  = {addr_q[AXI_ADDR_WIDTH-1:3], 3'b000};
  assign bus.axi_w_valid_o  = w_valid_q;
  assign bus.axi_w_data_o   = wdata_q;
  assign bus.axi_w_strb_o   = strb_q;
  assign bus.axi_b_ready_o  = b_ready_q;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_22050019_lsu_axi_master.sv
module tb_ysyx_22050019_lsu_axi_master;
  import ysyx_22050019_lsu_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  lsu_state_e dbg_state;
  int         cyc = 0;

  ysyx_22050019_lsu_axi_master_if bus_if ();

  ysyx_22050019_lsu_axi_master dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus_if),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int          checks = 0;
  int          failures = 0;
  logic [64:0] exp_q[$];   // {err, rdata} expected per response
  int          due_q[$];   // cycle number in which each response is due
  logic [63:0] last_aw_addr, last_w_data, last_rdata;
  logic [7:0]  last_w_strb;
  logic        last_err;
  logic        last_first_try;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string act, input string req);
    checks++;
    failures++;
    $display("FAIL %s: actual=%s required=%s", name, act, req);
  endtask

  // ---------------- behavioural model ----------------
  function automatic int m_bytes(logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic m_misaligned(logic [63:0] addr, logic [1:0] size);
    return (int'(addr % 64'd8) + m_bytes(size)) > 8;
  endfunction

  function automatic logic [7:0] m_strb(logic [63:0] addr, logic [1:0] size);
    logic [7:0] s;
    int lo;
    s  = '0;
    lo = int'(addr % 64'd8);
    for (int i = 0; i < m_bytes(size); i++)
      if (lo + i < 8) s[lo + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(logic [63:0] addr, logic [63:0] wdata);
    return wdata << (8 * int'(addr % 64'd8));
  endfunction

  function automatic logic [63:0] m_load(logic [63:0] raw, logic [63:0] addr,
                                         logic [1:0] size, logic sgn);
    logic [63:0] v;
    int lo, nb;
    v  = '0;
    lo = int'(addr % 64'd8);
    nb = m_bytes(size);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(lo+i) +: 8];
    if (sgn && v[8*nb-1])
      for (int j = nb; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  // ---------------- per-cycle compare process ----------------
  logic        p_ar, p_aw, p_w, aw_done;
  logic [63:0] p_ar_addr, p_aw_addr, p_w_data;
  logic [7:0]  p_w_strb;
  logic [64:0] mon_e;
  int          mon_d;

  always @(negedge clk) begin
    if (rst) begin
      p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0; aw_done = 1'b0;
    end else begin
      if (due_q.size() > 0 && cyc > due_q[0]) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        fail_now("resp_missing", "no pulse", "resp pulse");
      end
      if (bus_if.lsu_resp_valid_o) begin
        if (exp_q.size() == 0) begin
          fail_now("resp_unexpected", "resp pulse", "no pulse");
        end else begin
          mon_e = exp_q.pop_front();
          mon_d = due_q.pop_front();
          check("resp_cycle", cyc, mon_d);
          check("resp_rdata", bus_if.lsu_resp_rdata_o, mon_e[63:0]);
          check("resp_err", bus_if.lsu_resp_err_o, mon_e[64]);
          last_rdata = bus_if.lsu_resp_rdata_o;
          last_err   = bus_if.lsu_resp_err_o;
        end
      end
      if (p_ar) begin
        check("ar_valid_hold", bus_if.axi_ar_valid_o, 1);
        check("ar_addr_stable", bus_if.axi_ar_addr_o, p_ar_addr);
      end
      if (p_aw) begin
        check("aw_valid_hold", bus_if.axi_aw_valid_o, 1);
        check("aw_addr_stable", bus_if.axi_aw_addr_o, p_aw_addr);
      end
      if (p_w) begin
        check("w_valid_hold", bus_if.axi_w_valid_o, 1);
        check("w_data_stable", bus_if.axi_w_data_o, p_w_data);
        check("w_strb_stable", bus_if.axi_w_strb_o, p_w_strb);
      end
      if (bus_if.axi_w_valid_o) check("w_after_aw", aw_done, 1);
      p_ar      = bus_if.axi_ar_valid_o && !bus_if.axi_ar_ready_i;
      p_ar_addr = bus_if.axi_ar_addr_o;
      p_aw      = bus_if.axi_aw_valid_o && !bus_if.axi_aw_ready_i;
      p_aw_addr = bus_if.axi_aw_addr_o;
      p_w       = bus_if.axi_w_valid_o && !bus_if.axi_w_ready_i;
      p_w_data  = bus_if.axi_w_data_o;
      p_w_strb  = bus_if.axi_w_strb_o;
      if (bus_if.axi_aw_valid_o && bus_if.axi_aw_ready_i) aw_done = 1'b1;
      if (bus_if.axi_w_valid_o && bus_if.axi_w_ready_i)   aw_done = 1'b0;
    end
  end

  // ---------------- driver tasks (inputs change at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_req(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input logic sgn,
                          output logic acc, output logic first);
    bus_if.lsu_req_valid_i  = 1'b1;
    bus_if.lsu_req_wen_i    = wen;
    bus_if.lsu_req_addr_i   = addr;
    bus_if.lsu_req_wdata_i  = wdata;
    bus_if.lsu_req_size_i   = size;
    bus_if.lsu_req_signed_i = sgn;
    acc = 1'b0; first = 1'b0;
    for (int k = 0; k < 16 && !acc; k++) begin
      @(negedge clk);
      if (bus_if.lsu_req_ready_o) begin acc = 1'b1; first = (k == 0); end
      @(posedge clk); #1;
    end
    bus_if.lsu_req_valid_i = 1'b0;
    if (!acc) fail_now("req_accept_timeout", "not accepted", "accepted");
  endtask

  task automatic ar_phase(input logic [63:0] addr, input int stall);
    bus_if.axi_ar_ready_i = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (k == 0) check("ar_valid_latency", bus_if.axi_ar_valid_o, 1);
      @(posedge clk); #1;
    end
    bus_if.axi_ar_ready_i = 1'b1;
    @(negedge clk);
    check("ar_valid", bus_if.axi_ar_valid_o, 1);
    check("ar_addr", bus_if.axi_ar_addr_o, addr & ~64'd7);
    check("no_aw_on_load", bus_if.axi_aw_valid_o, 0);
    @(posedge clk); #1;
    bus_if.axi_ar_ready_i = 1'b0;
  endtask

  task automatic r_phase(input logic [63:0] addr, input logic [1:0] size, input logic sgn,
                         input int stall, input logic [63:0] raw, input logic [1:0] resp);
    idle(stall);
    bus_if.axi_r_valid_i = 1'b1;
    bus_if.axi_r_data_i  = raw;
    bus_if.axi_r_resp_i  = resp;
    @(negedge clk);
    check("r_ready", bus_if.axi_r_ready_o, 1);
    @(posedge clk); #1;
    bus_if.axi_r_valid_i = 1'b0;
    bus_if.axi_r_data_i  = '0;
    exp_q.push_back({resp != 2'b00, m_load(raw, addr, size, sgn)});
    due_q.push_back(cyc);
  endtask

  task automatic aw_phase(input logic [63:0] addr, input int stall);
    bus_if.axi_aw_ready_i = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (k == 0) check("aw_valid_latency", bus_if.axi_aw_valid_o, 1);
      @(posedge clk); #1;
    end
    bus_if.axi_aw_ready_i = 1'b1;
    @(negedge clk);
    check("aw_valid", bus_if.axi_aw_valid_o, 1);
    check("aw_addr", bus_if.axi_aw_addr_o, addr & ~64'd7);
    check("no_ar_on_store", bus_if.axi_ar_valid_o, 0);
    last_aw_addr = bus_if.axi_aw_addr_o;
    @(posedge clk); #1;
    bus_if.axi_aw_ready_i = 1'b0;
  endtask

  task automatic w_phase(input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] size, input int stall);
    idle(stall);
    bus_if.axi_w_ready_i = 1'b1;
    @(negedge clk);
    check("w_valid", bus_if.axi_w_valid_o, 1);
    check("w_data", bus_if.axi_w_data_o, m_wdata(addr, wdata));
    check("w_strb", bus_if.axi_w_strb_o, m_strb(addr, size));
    last_w_data = bus_if.axi_w_data_o;
    last_w_strb = bus_if.axi_w_strb_o;
    @(posedge clk); #1;
    bus_if.axi_w_ready_i = 1'b0;
  endtask

  task automatic b_phase(input int stall, input logic [1:0] resp);
    idle(stall);
    bus_if.axi_b_valid_i = 1'b1;
    bus_if.axi_b_resp_i  = resp;
    @(negedge clk);
    check("b_ready", bus_if.axi_b_ready_o, 1);
    @(posedge clk); #1;
    bus_if.axi_b_valid_i = 1'b0;
    exp_q.push_back({resp != 2'b00, 64'd0});
    due_q.push_back(cyc);
  endtask

  task automatic do_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [1:0] size, input logic sgn,
                        input int s1, input int s2, input int s3,
                        input logic [63:0] raw, input logic [1:0] resp);
    logic acc, first;
    send_req(wen, addr, wdata, size, sgn, acc, first);
    last_first_try = first;
    if (!acc) return;
    if (m_misaligned(addr, size)) begin
      exp_q.push_back({1'b1, 64'd0});
      due_q.push_back(cyc);
      @(negedge clk);
      check("err_no_ar", bus_if.axi_ar_valid_o, 0);
      check("err_no_aw", bus_if.axi_aw_valid_o, 0);
      @(posedge clk); #1;
    end else if (wen) begin
      aw_phase(addr, s1);
      w_phase(addr, wdata, size, s2);
      b_phase(s3, resp);
    end else begin
      ar_phase(addr, s1);
      r_phase(addr, size, sgn, s2, raw, resp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic acc, first;
    bus_if.lsu_req_valid_i  = 1'b0;
    bus_if.lsu_req_wen_i    = 1'b0;
    bus_if.lsu_req_addr_i   = '0;
    bus_if.lsu_req_wdata_i  = '0;
    bus_if.lsu_req_size_i   = 2'd0;
    bus_if.lsu_req_signed_i = 1'b0;
    bus_if.axi_aw_ready_i   = 1'b0;
    bus_if.axi_w_ready_i    = 1'b0;
    bus_if.axi_b_valid_i    = 1'b0;
    bus_if.axi_b_resp_i     = 2'b00;
    bus_if.axi_ar_ready_i   = 1'b0;
    bus_if.axi_r_valid_i    = 1'b0;
    bus_if.axi_r_resp_i     = 2'b00;
    bus_if.axi_r_data_i     = '0;
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check("rst_req_ready", bus_if.lsu_req_ready_o, 1);
    check("rst_resp_valid", bus_if.lsu_resp_valid_o, 0);
    check("rst_resp_rdata", bus_if.lsu_resp_rdata_o, 0);
    check("rst_resp_err", bus_if.lsu_resp_err_o, 0);
    check("rst_ar_valid", bus_if.axi_ar_valid_o, 0);
    check("rst_aw_valid", bus_if.axi_aw_valid_o, 0);
    check("rst_w_valid", bus_if.axi_w_valid_o, 0);
    check("rst_b_ready", bus_if.axi_b_ready_o, 0);
    check("rst_r_ready", bus_if.axi_r_ready_o, 0);
    check("rst_ar_addr", bus_if.axi_ar_addr_o, 0);
    check("rst_aw_addr", bus_if.axi_aw_addr_o, 0);
    check("rst_w_data", bus_if.axi_w_data_o, 0);
    check("rst_w_strb", bus_if.axi_w_strb_o, 0);
    check("rst_state", dbg_state, S_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // SD at a beat-aligned address
    do_txn(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 0, 0, 0, 64'd0, 2'b00);
    idle(1);
    check("sd_aw_addr", last_aw_addr, 64'h8000_0010);
    check("sd_w_data", last_w_data, 64'h1122_3344_5566_7788);
    check("sd_w_strb", last_w_strb, 8'hFF);
    check("sd_err", last_err, 0);

    // SB at offset 3
    do_txn(1'b1, 64'h8000_0013, 64'h0000_0000_0000_00AB, 2'd0, 1'b0, 1, 2, 1, 64'd0, 2'b00);
    idle(1);
    check("sb_aw_addr", last_aw_addr, 64'h8000_0010);
    check("sb_w_data", last_w_data, 64'h0000_0000_AB00_0000);
    check("sb_w_strb", last_w_strb, 8'h08);

    // LH / LHU from the top half-word
    do_txn(1'b0, 64'h8000_0006, 64'd0, 2'd1, 1'b1, 0, 0, 0, 64'h8001_0000_0000_0000, 2'b00);
    idle(1);
    check("lh_rdata", last_rdata, 64'hFFFF_FFFF_FFFF_8001);
    do_txn(1'b0, 64'h8000_0006, 64'd0, 2'd1, 1'b0, 0, 1, 0, 64'h8001_0000_0000_0000, 2'b00);
    idle(1);
    check("lhu_rdata", last_rdata, 64'h0000_0000_0000_8001);

    // Misaligned LW
    do_txn(1'b0, 64'h8000_0005, 64'd0, 2'd2, 1'b1, 0, 0, 0, 64'd0, 2'b00);
    idle(1);
    check("lw_mis_err", last_err, 1);
    check("lw_mis_rdata", last_rdata, 0);

    // SLVERR on a load and on a store
    do_txn(1'b0, 64'h8000_0020, 64'd0, 2'd2, 1'b0, 0, 0, 0, 64'h0123_4567_89AB_CDEF, 2'b10);
    idle(1);
    check("lw_slverr", last_err, 1);
    check("lw_slverr_rdata", last_rdata, 64'h0000_0000_89AB_CDEF);
    do_txn(1'b1, 64'h8000_0028, 64'h55, 2'd0, 1'b0, 0, 0, 0, 64'd0, 2'b11);
    idle(1);
    check("sb_decerr", last_err, 1);

    // Stalled load (AR ready after 5 cycles, R valid after 3) then back-to-back load
    do_txn(1'b0, 64'h8000_0040, 64'd0, 2'd3, 1'b0, 5, 3, 0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00);
    do_txn(1'b0, 64'h8000_0044, 64'd0, 2'd2, 1'b1, 0, 0, 0, 64'hF000_0000_1234_5678, 2'b00);
    check("b2b_accept_first_try", last_first_try, 1);
    idle(1);
    check("b2b_rdata", last_rdata, 64'hFFFF_FFFF_F000_0000);

    // Reset while the write data channel is pending
    send_req(1'b1, 64'h8000_0030, 64'hA5A5_A5A5_A5A5_A5A5, 2'd3, 1'b0, acc, first);
    if (acc) aw_phase(64'h8000_0030, 0);
    idle(2);
    check("pre_rst_w_valid", bus_if.axi_w_valid_o, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_w_valid", bus_if.axi_w_valid_o, 0);
    check("mid_rst_aw_valid", bus_if.axi_aw_valid_o, 0);
    check("mid_rst_b_ready", bus_if.axi_b_ready_o, 0);
    check("mid_rst_resp_valid", bus_if.lsu_resp_valid_o, 0);
    check("mid_rst_req_ready", bus_if.lsu_req_ready_o, 1);
    idle(2);
    rst = 1'b0;
    idle(3);
    do_txn(1'b1, 64'h8000_0032, 64'h0000_0000_0000_BEEF, 2'd1, 1'b0, 2, 1, 2, 64'd0, 2'b00);
    idle(1);
    check("post_rst_w_data", last_w_data, 64'h0000_0000_BEEF_0000);
    check("post_rst_w_strb", last_w_strb, 8'h0C);
    check("post_rst_err", last_err, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      logic        r_wen, r_sgn;
      logic [1:0]  r_size, r_resp;
      logic [63:0] r_addr, r_wdata, r_raw;
      r_wen   = 1'($urandom_range(0, 1));
      r_sgn   = 1'($urandom_range(0, 1));
      r_size  = 2'($urandom_range(0, 3));
      r_addr  = 64'h8000_0000 + 64'($urandom_range(0, 127));
      r_wdata = {$urandom, $urandom};
      r_raw   = {$urandom, $urandom};
      r_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(r_wen, r_addr, r_wdata, r_size, r_sgn,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             r_raw, r_resp);
      idle($urandom_range(0, 2));
    end

    idle(3);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=time limit reached required=bench finished");
    $fatal(1, "watchdog");
  end

endmodule
